// File: rtl/size_field_patcher.sv
// rtl/size_field_patcher.sv - queues size-field patch requests and writes them big-endian, one byte per cycle
// Requests never stall the producer: a full queue drops and flags, an illegal size flags.
module size_field_patcher #(
   parameter int FIFO_DEPTH = 4,
   parameter int ADDR_W     = 24
) (
   input  logic                          clock,
   input  logic                          reset_n,
   input  logic [31:0]                   req_offset_addr,
   input  logic [31:0]                   req_val,
   input  logic [31:0]                   req_byte_size,
   input  logic                          err_clear,
   output logic                          mem_we,
   output logic [ADDR_W-1:0]             mem_addr,
   output logic [7:0]                    mem_wdata,
   output logic                          done,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow,
   output logic                          size_err
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;

   typedef enum logic {IDLE, WRITE} state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   fifo_addr_q [FIFO_DEPTH];
   logic [31:0]         fifo_val_q  [FIFO_DEPTH];
   logic [2:0]          fifo_size_q [FIFO_DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [LVL_W-1:0]    level_q, level_d;

   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [7:0]          wdata_q, wdata_d;
   logic                done_q, done_d;
   logic [31:0]         cur_val_q, cur_val_d;
   logic [2:0]          rem_q, rem_d;
   logic                ovf_q, ovf_d;
   logic                serr_q, serr_d;

   logic                req_legal, req_bad;
   logic                fifo_empty, fifo_full;
   logic                push, pop, drop;
   logic [ADDR_W-1:0]   head_addr;
   logic [31:0]         head_val;
   logic [2:0]          head_size;
   logic [31:0]         aligned;
   logic                unused_offset_hi;

   assign unused_offset_hi = ^req_offset_addr;

   assign req_legal  = (req_byte_size != 32'd0) && (req_byte_size <= 32'd4);
   assign req_bad    = (req_byte_size > 32'd4);
   assign fifo_empty = (level_q == '0);
   assign fifo_full  = (level_q == LVL_W'(FIFO_DEPTH));
   assign pop        = (state_q == IDLE) && !fifo_empty;
   assign push       = req_legal && (!fifo_full || pop);
   assign drop       = req_legal && fifo_full && !pop;

   assign head_addr  = fifo_addr_q[rd_ptr_q];
   assign head_val   = fifo_val_q[rd_ptr_q];
   assign head_size  = fifo_size_q[rd_ptr_q];

   // Left-justify the field so the MS byte always sits in [31:24]; the shifter then just walks left.
   always_comb begin
      aligned = head_val;
      case (head_size)
         3'd1:    aligned = {head_val[7:0], 24'h0};
         3'd2:    aligned = {head_val[15:0], 16'h0};
         3'd3:    aligned = {head_val[23:0], 8'h0};
         default: aligned = head_val;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      we_d      = 1'b0;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      done_d    = 1'b0;
      cur_val_d = cur_val_q;
      rem_d     = rem_q;
      case (state_q)
         IDLE: begin
            if (pop) begin
               we_d      = 1'b1;
               addr_d    = head_addr;
               wdata_d   = aligned[31:24];
               cur_val_d = {aligned[23:0], 8'h0};
               if (head_size == 3'd1) begin
                  done_d = 1'b1;
               end else begin
                  rem_d   = head_size - 3'd1;
                  state_d = WRITE;
               end
            end
         end
         WRITE: begin
            we_d      = 1'b1;
            addr_d    = addr_q + ADDR_W'(1);
            wdata_d   = cur_val_q[31:24];
            cur_val_d = {cur_val_q[23:0], 8'h0};
            rem_d     = rem_q - 3'd1;
            if (rem_q == 3'd1) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      level_d = level_q;
      case ({push, pop})
         2'b10:   level_d = level_q + LVL_W'(1);
         2'b01:   level_d = level_q - LVL_W'(1);
         default: level_d = level_q;
      endcase
   end

   // A new error on the same edge as err_clear leaves the flag set.
   always_comb begin
      ovf_d  = err_clear ? 1'b0 : ovf_q;
      serr_d = err_clear ? 1'b0 : serr_q;
      if (drop)    ovf_d  = 1'b1;
      if (req_bad) serr_d = 1'b1;
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         level_q   <= '0;
         we_q      <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         done_q    <= 1'b0;
         cur_val_q <= '0;
         rem_q     <= '0;
         ovf_q     <= 1'b0;
         serr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         level_q   <= level_d;
         we_q      <= we_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         done_q    <= done_d;
         cur_val_q <= cur_val_d;
         rem_q     <= rem_d;
         ovf_q     <= ovf_d;
         serr_q    <= serr_d;
      end
   end

   always_ff @(posedge clock) begin
      if (push) begin
         fifo_addr_q[wr_ptr_q] <= req_offset_addr[ADDR_W-1:0];
         fifo_val_q[wr_ptr_q]  <= req_val;
         fifo_size_q[wr_ptr_q] <= req_byte_size[2:0];
      end
   end

   assign mem_we     = we_q;
   assign mem_addr   = addr_q;
   assign mem_wdata  = wdata_q;
   assign done       = done_q;
   assign busy       = !fifo_empty || (state_q == WRITE);
   assign fifo_level = level_q;
   assign overflow   = ovf_q;
   assign size_err   = serr_q;

endmodule

// File: tb/tb_size_field_patcher.sv
// tb/tb_size_field_patcher.sv - scoreboard bench for size_field_patcher
// Expected byte writes are queued when a request is accepted; a negedge monitor pops and compares.
module tb_size_field_patcher;

   localparam int DEPTH = 4;
   localparam int AW    = 24;

   logic              clock = 1'b0;
   logic              reset_n;
   logic [31:0]       req_offset_addr, req_val, req_byte_size;
   logic              err_clear;
   logic              mem_we;
   logic [AW-1:0]     mem_addr;
   logic [7:0]        mem_wdata;
   logic              done, busy;
   logic [2:0]        fifo_level;
   logic              overflow, size_err;

   always #5 clock = ~clock;

   size_field_patcher #(.FIFO_DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clock(clock), .reset_n(reset_n),
      .req_offset_addr(req_offset_addr), .req_val(req_val), .req_byte_size(req_byte_size),
      .err_clear(err_clear),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .done(done), .busy(busy), .fifo_level(fifo_level),
      .overflow(overflow), .size_err(size_err)
   );

   typedef struct {
      logic [AW-1:0] addr;
      logic [7:0]    data;
      bit            last;
   } wr_t;

   wr_t  sb[$];
   int   req_q[$];
   int   eng_left = 0;
   bit   m_ov = 0, m_se = 0, exp_we = 0, armed = 0;
   int   n_chk = 0, n_pass = 0;

   task automatic chk(string nm, longint act, longint exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
   endtask

   // Model: the engine emits one byte per cycle; a queued request starts only once the previous one is fully issued.
   task automatic step(bit rn, logic [31:0] off, logic [31:0] val, logic [31:0] sz, bit clr);
      bit  pop, legal, bad;
      int  lenb;
      wr_t w;
      reset_n = rn; req_offset_addr = off; req_val = val; req_byte_size = sz; err_clear = clr;
      @(posedge clock);
      if (!rn) begin
         req_q.delete(); sb.delete();
         eng_left = 0; m_ov = 0; m_se = 0; exp_we = 0;
      end else begin
         lenb  = req_q.size();
         legal = (sz >= 1) && (sz <= 4);
         bad   = (sz > 4);
         pop   = (eng_left == 0) && (lenb > 0);
         exp_we = (eng_left > 0) || pop;
         if (eng_left > 0) eng_left--;
         else if (pop) eng_left = req_q.pop_front() - 1;
         if (clr) begin m_ov = 0; m_se = 0; end
         if (bad) m_se = 1;
         if (legal) begin
            if (lenb < DEPTH || pop) begin
               req_q.push_back(int'(sz));
               for (int i = 0; i < int'(sz); i++) begin
                  w.addr = AW'(off + 32'(i));
                  w.data = 8'((val >> (8 * (int'(sz) - 1 - i))) & 32'hFF);
                  w.last = (i == int'(sz) - 1);
                  sb.push_back(w);
               end
            end else m_ov = 1;
         end
      end
      #1;
      chk("mem_we", mem_we, exp_we);
      chk("fifo_level", fifo_level, req_q.size());
      chk("overflow", overflow, m_ov);
      chk("size_err", size_err, m_se);
      chk("busy", busy, (req_q.size() != 0) || (eng_left != 0));
      if (!rn) begin
         chk("rst_addr", mem_addr, 0);
         chk("rst_wdata", mem_wdata, 0);
         chk("rst_done", done, 0);
      end
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0);
   endtask

   always @(negedge clock) begin
      wr_t e;
      if (armed) begin
         if (mem_we) begin
            if (sb.size() == 0) chk("spurious_write", 1, 0);
            else begin
               e = sb.pop_front();
               chk("wr_addr", mem_addr, e.addr);
               chk("wr_data", mem_wdata, e.data);
               chk("wr_done", done, e.last);
            end
         end else chk("done_idle", done, 0);
      end
   end

   initial begin
      int r;
      logic [31:0] sz;
      step(0, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      armed = 1;
      idle(2);

      step(1, 32'h20, 32'h1234, 2, 0);
      idle(4);

      step(1, 32'h8, 32'h0001A2B3, 4, 0);
      step(1, 32'h40, 32'hFFFFFF5A, 1, 0);
      idle(6);

      for (int k = 0; k < 7; k++) step(1, 32'h100 + 32'(4 * k), $urandom, 4, 0);
      chk("burst_overflow", overflow, 1);
      idle(30);
      step(1, 0, 0, 0, 1);

      step(1, 32'h10, 32'h55, 5, 0);
      step(1, 32'h10, 32'h55, 32'h100, 0);
      chk("illegal_flag", size_err, 1);
      step(1, 0, 0, 0, 1);
      chk("err_clear", size_err, 0);
      step(1, 32'h10, 32'h55, 7, 1);
      chk("clear_vs_set", size_err, 1);
      step(1, 0, 0, 0, 1);

      step(1, 32'h00FFFFFF, 32'h0000BEEF, 2, 0);
      idle(3);

      step(1, 32'h300, 32'hCAFEF00D, 4, 0);
      step(1, 32'h310, 32'h11223344, 3, 0);
      step(1, 32'h320, 32'h00000077, 2, 0);
      step(0, 0, 0, 0, 0);
      idle(6);

      for (int n = 0; n < 3000; n++) begin
         r = $urandom_range(0, 99);
         if (r < 40) sz = 0;
         else if (r < 93) sz = $urandom_range(1, 4);
         else if (r < 97) sz = $urandom_range(5, 300);
         else sz = $urandom;
         step(($urandom_range(0, 199) != 0), $urandom, $urandom, sz, ($urandom_range(0, 29) == 0));
      end
      idle(30);
      chk("scoreboard_drained", sb.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
